// File: rtl/ex_pkg.sv
// rtl/ex_pkg.sv - shared RV32M constants, FSM state type and operand-signedness helpers
package ex_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [6:0] OPCODE_OP = 7'b0110011;
    localparam logic [6:0] FUNCT7_M  = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic f3_a_signed(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
               (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic f3_b_signed(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/ex_muldiv_step.sv
// rtl/ex_muldiv_step.sv - one shift-add (mul) or restoring-subtract (div) iteration on the {hi,lo} accumulator
module ex_muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic              is_div,
    input  logic [2*XLEN-1:0] acc_in,
    input  logic [XLEN-1:0]   operand,
    output logic [2*XLEN-1:0] acc_out
);

    logic [XLEN:0] add_sum;
    logic [XLEN:0] rem_sh;
    logic [XLEN:0] diff;

    always_comb begin
        add_sum = {1'b0, acc_in[2*XLEN-1:XLEN]} + (acc_in[0] ? {1'b0, operand} : '0);
        rem_sh  = acc_in[2*XLEN-1:XLEN-1];
        diff    = rem_sh - {1'b0, operand};
        acc_out = {add_sum, acc_in[XLEN-1:1]};
        if (is_div) begin
            // diff[XLEN] is the borrow: set means the trial subtraction is restored
            if (!diff[XLEN]) begin
                acc_out = {diff[XLEN-1:0], acc_in[XLEN-2:0], 1'b1};
            end else begin
                acc_out = {rem_sh[XLEN-1:0], acc_in[XLEN-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - iterative RV32M multiply/divide unit; EX_MULDIV_FAST_MUL_EN selects single-cycle multiplies
module ex_muldiv
    import ex_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [RD_W-1:0] rd,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [RD_W-1:0] out_rd,
    output logic            busy
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    state_t state, state_nxt;
    logic   accept;

    logic [2:0]        f3_q;
    logic [RD_W-1:0]   rd_q;
    logic [XLEN-1:0]   opnd_q;
    logic [2*XLEN-1:0] acc_q, acc_step;
    logic              neg_q, skip_q;
    logic [CNT_W-1:0]  cnt_q;

    logic            a_neg, b_neg, res_neg_in, div_zero, div_ovf;
    logic [XLEN-1:0] mag_a, mag_b, spec_val;

    function automatic logic [XLEN-1:0] fixup(input logic [2:0] f3, input logic neg,
                                              input logic [2*XLEN-1:0] acc);
        logic [XLEN-1:0]   val;
        logic [2*XLEN-1:0] prod;
        if (f3[2]) begin
            val = f3[1] ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
            return neg ? -val : val;
        end
        prod = neg ? -acc : acc;
        return (f3 == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    endfunction

    always_comb begin
        a_neg      = f3_a_signed(funct3) & op_a[XLEN-1];
        b_neg      = f3_b_signed(funct3) & op_b[XLEN-1];
        mag_a      = a_neg ? -op_a : op_a;
        mag_b      = b_neg ? -op_b : op_b;
        div_zero   = (op_b == '0);
        div_ovf    = funct3[2] && !funct3[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
        // remainder takes the dividend's sign; quotient and products the xor of both
        res_neg_in = (funct3[2] && funct3[1]) ? a_neg : (a_neg ^ b_neg);
        if (div_zero) begin
            spec_val = funct3[1] ? op_a : '1;
        end else begin
            spec_val = funct3[1] ? '0 : op_a;
        end
    end

`ifdef EX_MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
    assign fast_prod = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
`endif

    ex_muldiv_step #(.XLEN(XLEN)) u_step (
        .is_div  (f3_q[2]),
        .acc_in  (acc_q),
        .operand (opnd_q),
        .acc_out (acc_step)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = (state == S_IDLE) && !flush;
        out_valid = (state == S_DONE);
        busy      = (state == S_CALC) || (state == S_DONE);
        accept    = in_valid && in_ready;
        case (state)
            S_IDLE: begin
                if (accept) begin
`ifdef EX_MULDIV_FAST_MUL_EN
                    state_nxt = funct3[2] ? S_CALC : S_DONE;
`else
                    state_nxt = S_CALC;
`endif
                end
            end
            S_CALC: begin
                if (skip_q || (cnt_q == CNT_W'(XLEN - 1))) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (flush) begin
            state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f3_q       <= '0;
            rd_q       <= '0;
            opnd_q     <= '0;
            acc_q      <= '0;
            neg_q      <= 1'b0;
            skip_q     <= 1'b0;
            cnt_q      <= '0;
            out_result <= '0;
            out_rd     <= '0;
        end else if (accept) begin
            f3_q  <= funct3;
            rd_q  <= rd;
            neg_q <= res_neg_in;
            cnt_q <= '0;
            if (funct3[2]) begin
                // corner-case divides park their final answer in the low half and bypass iteration
                opnd_q <= mag_b;
                acc_q  <= {{XLEN{1'b0}}, (div_zero || div_ovf) ? spec_val : mag_a};
                skip_q <= div_zero || div_ovf;
            end else begin
                opnd_q <= mag_a;
                acc_q  <= {{XLEN{1'b0}}, mag_b};
                skip_q <= 1'b0;
`ifdef EX_MULDIV_FAST_MUL_EN
                out_result <= fixup(funct3, res_neg_in, fast_prod);
                out_rd     <= rd;
`endif
            end
        end else if (state == S_CALC && !flush) begin
            if (skip_q) begin
                out_result <= acc_q[XLEN-1:0];
                out_rd     <= rd_q;
            end else begin
                acc_q <= acc_step;
                cnt_q <= cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(XLEN - 1)) begin
                    out_result <= fixup(f3_q, neg_q, acc_step);
                    out_rd     <= rd_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// tb/tb_ex_muldiv.sv - directed vector table plus hold, flush and async-reset sequences for ex_muldiv
module tb_ex_muldiv;
    import ex_pkg::*;

    localparam int XLEN = 32;
    localparam int RD_W = 5;
`ifdef EX_MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT  = 33;
    localparam int SPEC_LAT = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [2:0]      funct3 = 3'b000;
    logic [XLEN-1:0] op_a = '0;
    logic [XLEN-1:0] op_b = '0;
    logic [RD_W-1:0] rd = '0;
    logic            flush = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [XLEN-1:0] out_result;
    logic [RD_W-1:0] out_rd;
    logic            busy;

    ex_muldiv #(.XLEN(XLEN), .RD_W(RD_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .funct3     (funct3),
        .op_a       (op_a),
        .op_b       (op_b),
        .rd         (rd),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_rd     (out_rd),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0]      f3;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [RD_W-1:0] rd;
        logic [XLEN-1:0] res;
        int              lat;
    } vec_t;

    vec_t vt[16];

    // drives one op from an IDLE state; returns cycles from the accept cycle to first out_valid
    task automatic issue(input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [RD_W-1:0] t, output int lat);
        funct3   = f3;
        op_a     = a;
        op_b     = b;
        rd       = t;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        int seen;
        logic [XLEN-1:0] held;

        vt[0]  = '{F3_MUL,    32'd7,          32'hFFFFFFFD, 5'd3,  32'hFFFFFFEB, MUL_LAT};
        vt[1]  = '{F3_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF, 5'd4,  32'hFFFFFFFE, MUL_LAT};
        vt[2]  = '{F3_MULH,   32'hFFFFFFFF,   32'hFFFFFFFF, 5'd5,  32'h00000000, MUL_LAT};
        vt[3]  = '{F3_MULHSU, 32'hFFFFFFFF,   32'hFFFFFFFF, 5'd6,  32'hFFFFFFFF, MUL_LAT};
        vt[4]  = '{F3_DIV,    32'h80000000,   32'hFFFFFFFF, 5'd7,  32'h80000000, SPEC_LAT};
        vt[5]  = '{F3_REM,    32'h80000000,   32'hFFFFFFFF, 5'd8,  32'h00000000, SPEC_LAT};
        vt[6]  = '{F3_DIVU,   32'd5,          32'd0,        5'd9,  32'hFFFFFFFF, SPEC_LAT};
        vt[7]  = '{F3_REMU,   32'd5,          32'd0,        5'd10, 32'd5,        SPEC_LAT};
        vt[8]  = '{F3_DIV,    32'hFFFFFFF9,   32'd2,        5'd11, 32'hFFFFFFFD, DIV_LAT};
        vt[9]  = '{F3_REM,    32'hFFFFFFF9,   32'd2,        5'd12, 32'hFFFFFFFF, DIV_LAT};
        vt[10] = '{F3_DIVU,   32'd100,        32'd7,        5'd13, 32'd14,       DIV_LAT};
        vt[11] = '{F3_MUL,    32'd6,          32'd7,        5'd14, 32'd42,       MUL_LAT};
        vt[12] = '{F3_DIV,    32'd20,         32'hFFFFFFFD, 5'd15, 32'hFFFFFFFA, DIV_LAT};
        vt[13] = '{F3_REM,    32'd20,         32'hFFFFFFFD, 5'd16, 32'd2,        DIV_LAT};
        vt[14] = '{F3_REM,    32'hFFFFFFFB,   32'd0,        5'd17, 32'hFFFFFFFB, SPEC_LAT};
        vt[15] = '{F3_MULH,   32'h80000000,   32'h80000000, 5'd31, 32'h40000000, MUL_LAT};

        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid",  32'(out_valid),  32'd0);
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_in_ready",   32'(in_ready),   32'd1);
        check("rst_out_result", out_result,      32'd0);
        check("rst_out_rd",     32'(out_rd),     32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd1);
            issue(vt[i].f3, vt[i].a, vt[i].b, vt[i].rd, lat);
            check($sformatf("v%0d_lat", i), 32'(lat), 32'(vt[i].lat));
            check($sformatf("v%0d_result", i), out_result, vt[i].res);
            check($sformatf("v%0d_rd", i), 32'(out_rd), 32'(vt[i].rd));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_valid_drop", i), 32'(out_valid), 32'd0);
        end

        // result held while writeback stalls
        out_ready = 1'b0;
        issue(F3_DIV, 32'hFFFFFFF9, 32'd2, 5'd21, lat);
        check("hold_lat", 32'(lat), 32'(DIV_LAT));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("hold%0d_valid", i),  32'(out_valid), 32'd1);
            check($sformatf("hold%0d_result", i), out_result,     32'hFFFFFFFD);
            check($sformatf("hold%0d_busy", i),   32'(busy),      32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("hold_release_valid", 32'(out_valid), 32'd0);
        check("hold_release_busy",  32'(busy),      32'd0);
        check("hold_after_result",  out_result,     32'hFFFFFFFD);

        // flush at CALC step 10, with a competing in_valid that must be ignored
        funct3 = F3_DIVU; op_a = 32'd1000; op_b = 32'd3; rd = 5'd22; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("flush_pre_busy", 32'(busy), 32'd1);
        flush = 1'b1;
        funct3 = F3_MUL; op_a = 32'd2; op_b = 32'd2; in_valid = 1'b1;
        #1;
        check("flush_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_busy",  32'(busy),      32'd0);
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid || busy) seen++;
        end
        check("flush_no_result", 32'(seen), 32'd0);
        issue(F3_DIVU, 32'd100, 32'd7, 5'd23, lat);
        check("post_flush_lat",    32'(lat),    32'(DIV_LAT));
        check("post_flush_result", out_result,  32'd14);
        check("post_flush_rd",     32'(out_rd), 32'd23);
        @(posedge clk);
        #1;

        // asynchronous reset in the middle of an iterative divide
        held = out_result;
        funct3 = F3_DIVU; op_a = 32'd500; op_b = 32'd9; rd = 5'd24; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_prev_result_nonzero", 32'(held != 0), 32'd1);
        check("arst_valid",  32'(out_valid),  32'd0);
        check("arst_busy",   32'(busy),       32'd0);
        check("arst_result", out_result,      32'd0);
        check("arst_rd",     32'(out_rd),     32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        issue(F3_MUL, 32'd6, 32'd7, 5'd25, lat);
        check("arst_first_lat",    32'(lat),    32'(MUL_LAT));
        check("arst_first_result", out_result,  32'd42);
        check("arst_first_rd",     32'(out_rd), 32'd25);
        @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 Parameter XLEN, default 32, operand/result width.
REQ-002 Parameter RD_W, default 5, destination register index width.
REQ-003 clk  input  1  single clock, all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  execute stage presents an RV32M op.
REQ-006 in_ready  output  1  unit accepts op this cycle.
REQ-007 funct3  input  3  M-extension op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-008 op_a, op_b  input  XLEN  forwarded rs1/rs2 values.
REQ-009 rd  input  RD_W  destination tag, carried through.
REQ-010 flush  input  1  branch/jump flush from execute, kills in-flight op.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  writeback consumes result.
REQ-013 out_result  output  XLEN  result; out_rd  output  RD_W  tag.
REQ-014 busy  output  1  stall request to pipeline, high in CALC or DONE.

Function
REQ-015 FSM states IDLE, CALC, DONE; in_ready = (state==IDLE) and not flush.
REQ-016 Accept when in_valid and in_ready: latch funct3, rd, operand magnitudes and result-sign flags.
REQ-017 Signedness: MUL/MULH/DIV/REM signed both operands; MULHSU op_a signed, op_b unsigned; MULHU/DIVU/REMU unsigned.
REQ-018 Iterative op: IDLE->CALC on accept; one shift-add (mul) or restoring-subtract (div) step per cycle; XLEN steps; CALC->DONE after step XLEN; out_valid first high XLEN+1 cycles after accept edge.
REQ-019 Multiply: 2*XLEN-bit product; MUL returns low XLEN bits, MULH* high XLEN bits, sign applied via two's-complement of full product.
REQ-020 Divide by zero: skip CALC, DONE next cycle; quotient all ones, remainder = op_a.
REQ-021 Signed overflow (op_a = most-negative, op_b = -1, DIV/REM): skip CALC; quotient = op_a, remainder 0.
REQ-022 Remainder sign follows dividend; quotient negated when operand signs differ (non-zero divisor).
REQ-023 DONE: out_valid high, out_result/out_rd stable until out_ready; DONE->IDLE on out_ready.
REQ-024 flush high in any state: next state IDLE, out_valid low next cycle, no result emitted; in_valid in same cycle ignored.
REQ-025 out_result and out_rd hold last value outside DONE; only out_valid qualifies them.

Reset
REQ-026 rst_n low: state IDLE, out_valid 0, busy 0, out_result 0, out_rd 0, step counter 0, immediately and independent of clk.
REQ-027 Reset mid-CALC discards op; first accept possible on first edge after rst_n rises.

Configuration
REQ-028 Macro EX_MULDIV_FAST_MUL_EN defined: multiplies use a single-cycle array multiply, IDLE->DONE directly, out_valid one cycle after accept; divides unchanged.
REQ-029 Macro undefined: all multiplies iterative per REQ-018.

Structure
REQ-030 Shared package ex_pkg: funct3 M-op constants, state enum, XLEN default, OPCODE_OP (0110011) and funct7 M value (0000001).
REQ-031 One sub-module ex_muldiv_step: combinational single-iteration shift-add/restoring-subtract datapath; FSM, sign fix-up, handshake in ex_muldiv.

Verification
REQ-032 MUL 7 x -3 (iterative) -> out_valid at accept+33, out_result 0xFFFFFFEB, out_rd echoed.
REQ-033 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU -1 x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-034 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 at accept+2; REM same -> 0; DIVU 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5.
REQ-035 DIV -7/2 -> 0xFFFFFFFD, REM -7/2 -> 0xFFFFFFFF; out_ready held low 5 cycles -> result held stable, busy high.
REQ-036 flush at CALC step 10 -> IDLE next cycle, no out_valid; new DIVU 100/7 accepted after -> 14; rst_n low mid-CALC -> outputs 0 asynchronously.
REQ-037 With EX_MULDIV_FAST_MUL_EN: MUL 6 x 7 -> 42 with out_valid one cycle after accept.
